// File: rtl/wash_pkg.sv
// Shared encodings for the washing-machine program sequencer:
// state codes (also driven on phase), timer run_state codes and motor codes.
package wash_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WASH  = 3'd1,
        ST_RINSE = 3'd2,
        ST_SPIN  = 3'd3,
        ST_PAUSE = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

    localparam logic [1:0] RUN_IDLE  = 2'b00;
    localparam logic [1:0] RUN_RUN   = 2'b01;
    localparam logic [1:0] RUN_PAUSE = 2'b10;

    localparam logic [1:0] MOTOR_OFF     = 2'b00;
    localparam logic [1:0] MOTOR_AGITATE = 2'b01;
    localparam logic [1:0] MOTOR_SPIN    = 2'b10;

    // WASH and RINSE share the fill-then-agitate behaviour.
    function automatic logic is_fill(input state_t s);
        return (s == ST_WASH) || (s == ST_RINSE);
    endfunction

endpackage

// File: rtl/wash_sequencer_btn_edge.sv
// Registered rising-edge detector: press pulses one cycle, one edge after
// the button level is first sampled high.
module btn_edge (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic press
);

    logic btn_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btn_q <= 1'b0;
            press <= 1'b0;
        end else begin
            btn_q <= btn;
            press <= btn & ~btn_q;
        end
    end

endmodule

// File: rtl/wash_sequencer.sv
// Program sequencer: drives the timer run_state, splits rest_time into
// WASH/RINSE/SPIN phases and drives valve, drain, motor and buzzer.
module wash_sequencer
    import wash_pkg::*;
#(
    parameter int RINSE_T  = 20,
    parameter int SPIN_T   = 10,
    parameter int FILL_CYC = 50_000_000,
    parameter int BUZZ_CYC = 200_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       power_light,
    input  logic       start_pause,
    input  logic       door_open,
    input  logic [6:0] rest_time,
    output logic [1:0] run_state,
    output logic [2:0] phase,
    output logic       water_in,
    output logic       drain,
    output logic [1:0] motor,
    output logic       buzzer
);

    localparam logic [6:0]  TH_RINSE  = 7'(RINSE_T + SPIN_T);
    localparam logic [6:0]  TH_SPIN   = 7'(SPIN_T);
    localparam logic [31:0] FILL_MAX  = 32'(FILL_CYC);
    localparam logic [31:0] BUZZ_LAST = 32'(BUZZ_CYC - 1);

    state_t      state, state_n, saved, saved_n;
    logic [31:0] fill_cnt, fill_n, buzz_cnt, buzz_n;
    logic [1:0]  run_state_n, motor_n;
    logic        water_n, drain_n, buzzer_n;
    logic        press;

    btn_edge u_btn_edge (
        .clk   (clk),
        .rst   (rst),
        .btn   (start_pause),
        .press (press)
    );

    function automatic state_t start_phase(input logic [6:0] rt);
        if (rt > TH_RINSE)
            return ST_WASH;
        else if (rt > TH_SPIN)
            return ST_RINSE;
        else
            return ST_SPIN;
    endfunction

    always_comb begin
        state_n = state;
        saved_n = saved;
        fill_n  = fill_cnt;
        buzz_n  = 32'd0;
        if (!power_light) begin
            state_n = ST_IDLE;
            saved_n = ST_WASH;
            fill_n  = 32'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (press && rest_time != 7'd0 && !door_open)
                        state_n = start_phase(rest_time);
                end
                ST_WASH, ST_RINSE, ST_SPIN: begin
                    if (rest_time == 7'd0) begin
                        state_n = ST_DONE;
                    end else if (door_open || press) begin
                        state_n = ST_PAUSE;
                        saved_n = state;
                    end else if (state == ST_WASH && rest_time <= TH_RINSE) begin
                        state_n = ST_RINSE;
                    end else if (state == ST_RINSE && rest_time <= TH_SPIN) begin
                        state_n = ST_SPIN;
                    end
                end
                ST_PAUSE: begin
                    if (press && !door_open)
                        state_n = saved;
                end
                ST_DONE: begin
                    if (press || buzz_cnt == BUZZ_LAST)
                        state_n = ST_IDLE;
                end
                default: state_n = ST_IDLE;
            endcase

            // fill_cnt counts active fill cycles; frozen while paused, kept on resume.
            if (is_fill(state_n) && state_n != state && state != ST_PAUSE)
                fill_n = 32'd0;
            else if (is_fill(state) && fill_cnt != FILL_MAX)
                fill_n = fill_cnt + 32'd1;

            if (state == ST_DONE && state_n == ST_DONE)
                buzz_n = buzz_cnt + 32'd1;
        end
    end

    // Outputs are decoded from the next state so they register with it.
    always_comb begin
        run_state_n = RUN_IDLE;
        motor_n     = MOTOR_OFF;
        water_n     = 1'b0;
        drain_n     = 1'b0;
        buzzer_n    = 1'b0;
        case (state_n)
            ST_WASH, ST_RINSE: begin
                run_state_n = RUN_RUN;
                water_n     = (fill_n < FILL_MAX);
                motor_n     = water_n ? MOTOR_OFF : MOTOR_AGITATE;
            end
            ST_SPIN: begin
                run_state_n = RUN_RUN;
                drain_n     = 1'b1;
                motor_n     = MOTOR_SPIN;
            end
            ST_PAUSE: run_state_n = RUN_PAUSE;
            ST_DONE:  buzzer_n    = 1'b1;
            default:  run_state_n = RUN_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            saved     <= ST_WASH;
            fill_cnt  <= 32'd0;
            buzz_cnt  <= 32'd0;
            run_state <= RUN_IDLE;
            water_in  <= 1'b0;
            drain     <= 1'b0;
            motor     <= MOTOR_OFF;
            buzzer    <= 1'b0;
        end else begin
            state     <= state_n;
            saved     <= saved_n;
            fill_cnt  <= fill_n;
            buzz_cnt  <= buzz_n;
            run_state <= run_state_n;
            water_in  <= water_n;
            drain     <= drain_n;
            motor     <= motor_n;
            buzzer    <= buzzer_n;
        end
    end

    assign phase = state;

endmodule

// File: tb/tb_wash_sequencer.sv
// Bench for wash_sequencer: directed program walk-throughs then random
// button/door/power/rest_time activity, all against a phase-level model.
module tb_wash_sequencer;

    localparam int RINSE_T  = 20;
    localparam int SPIN_T   = 10;
    localparam int FILL_CYC = 6;
    localparam int BUZZ_CYC = 5;

    logic       clk = 1'b0;
    logic       rst, power_light, start_pause, door_open;
    logic [6:0] rest_time;
    logic [1:0] run_state, motor;
    logic [2:0] phase;
    logic       water_in, drain, buzzer;

    wash_sequencer #(
        .RINSE_T (RINSE_T),
        .SPIN_T  (SPIN_T),
        .FILL_CYC(FILL_CYC),
        .BUZZ_CYC(BUZZ_CYC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .power_light(power_light),
        .start_pause(start_pause),
        .door_open  (door_open),
        .rest_time  (rest_time),
        .run_state  (run_state),
        .phase      (phase),
        .water_in   (water_in),
        .drain      (drain),
        .motor      (motor),
        .buzzer     (buzzer)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Model: phase number, saved phase, active fill cycles used, DONE cycles,
    // and the button history that makes a registered press.
    int m_phase, m_saved, m_used, m_done;
    bit m_spq, m_press;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic bit fill_ph(input int p);
        return (p == 1) || (p == 2);
    endfunction

    task automatic model_reset();
        m_phase = 0; m_saved = 1; m_used = 0; m_done = 0;
        m_spq = 1'b0; m_press = 1'b0;
    endtask

    task automatic model_edge();
        bit pr;
        int old, r;
        pr      = m_press;
        m_press = start_pause && !m_spq;
        m_spq   = start_pause;
        r       = int'(rest_time);
        old     = m_phase;
        if (!power_light) begin
            m_phase = 0; m_used = 0; m_done = 0;
            return;
        end
        if (fill_ph(old)) m_used++;
        if (old == 5) m_done++;
        case (old)
            0: if (pr && r != 0 && !door_open)
                   m_phase = (r > RINSE_T + SPIN_T) ? 1 : (r > SPIN_T) ? 2 : 3;
            1, 2, 3: begin
                if (r == 0) m_phase = 5;
                else if (door_open || pr) begin m_saved = old; m_phase = 4; end
                else if (old == 1 && r <= RINSE_T + SPIN_T) m_phase = 2;
                else if (old == 2 && r <= SPIN_T) m_phase = 3;
            end
            4: if (pr && !door_open) m_phase = m_saved;
            5: if (pr || m_done == BUZZ_CYC) m_phase = 0;
            default: m_phase = 0;
        endcase
        if (fill_ph(m_phase) && old != m_phase && old != 4) m_used = 0;
        if (m_phase == 5 && old != 5) m_done = 0;
    endtask

    task automatic check_outputs();
        int e_run, e_motor;
        bit e_water;
        e_water = fill_ph(m_phase) && (m_used < FILL_CYC);
        e_run   = (m_phase == 4) ? 2 : (m_phase >= 1 && m_phase <= 3) ? 1 : 0;
        e_motor = fill_ph(m_phase) ? (e_water ? 0 : 1) : (m_phase == 3) ? 2 : 0;
        check("phase",     32'(phase),     32'(m_phase));
        check("run_state", 32'(run_state), 32'(e_run));
        check("water_in",  32'(water_in),  32'(e_water));
        check("drain",     32'(drain),     32'(m_phase == 3));
        check("motor",     32'(motor),     32'(e_motor));
        check("buzzer",    32'(buzzer),    32'(m_phase == 5));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic press_btn();
        start_pause = 1'b1;
        steps(2);
        start_pause = 1'b0;
        step();
    endtask

    task automatic power_cycle();
        power_light = 1'b0;
        step();
        power_light = 1'b1;
        step();
    endtask

    initial begin
        rst = 1'b1; power_light = 1'b1; start_pause = 1'b0;
        door_open = 1'b0; rest_time = 7'd0;
        model_reset();
        #2;
        check_outputs();
        @(negedge clk);
        rst = 1'b0;

        // Full program from WASH through DONE and back to IDLE.
        rest_time = 7'd40; press_btn();
        steps(8);
        rest_time = 7'd31; step();
        rest_time = 7'd30; step();
        check("enter_rinse", 32'(phase), 32'd2);
        steps(8);
        rest_time = 7'd10; step();
        check("enter_spin", 32'(phase), 32'd3);
        steps(2);
        rest_time = 7'd0; step();
        check("enter_done", 32'(phase), 32'd5);
        steps(6);
        check("done_to_idle", 32'(phase), 32'd0);

        // Direct entry selection and ignored start.
        rest_time = 7'd15; press_btn();
        check("direct_rinse", 32'(phase), 32'd2);
        power_cycle();
        rest_time = 7'd5; press_btn();
        check("direct_spin", 32'(phase), 32'd3);
        power_cycle();
        rest_time = 7'd0; press_btn();
        check("zero_no_start", 32'(run_state), 32'd0);

        // Pause mid-fill then resume with fill count retained.
        rest_time = 7'd40; press_btn();
        steps(1);
        press_btn();
        check("pause_run", 32'(run_state), 32'd2);
        steps(2);
        press_btn();
        steps(8);

        // Door pause in RINSE; press ignored while door open.
        rest_time = 7'd25; step();
        steps(2);
        door_open = 1'b1; step();
        press_btn();
        check("door_hold", 32'(phase), 32'd4);
        door_open = 1'b0; step();
        press_btn();
        check("door_resume", 32'(phase), 32'd2);

        // rest_time to 0 and press together in SPIN, then press lands in DONE.
        rest_time = 7'd8; step();
        rest_time = 7'd0; start_pause = 1'b1; step();
        start_pause = 1'b0; steps(2);

        // Power loss during SPIN.
        rest_time = 7'd9; press_btn();
        power_light = 1'b0; step();
        power_light = 1'b1; step();

        // Asynchronous reset mid-WASH.
        rest_time = 7'd40; press_btn();
        steps(2);
        #2 rst = 1'b1;
        #1 model_reset();
        check_outputs();
        @(negedge clk);
        rst = 1'b0;
        step();

        // Random activity.
        for (int c = 0; c < 2500; c++) begin
            case ($urandom_range(0, 9))
                0, 1, 2: if (rest_time != 7'd0) rest_time = rest_time - 7'd1;
                3:       rest_time = 7'($urandom_range(0, 60));
                4:       if ($urandom_range(0, 3) == 0) rest_time = 7'd0;
                default: ;
            endcase
            if ($urandom_range(0, 5) == 0) start_pause = ~start_pause;
            if ($urandom_range(0, 19) == 0) door_open = ~door_open;
            power_light = ($urandom_range(0, 149) != 0);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
